// File: rtl/truth_table_probe.sv
// truth_table_probe: sweeps the 8 input rows of a 3-input gate, holds each row
// for SETTLE_CYCLES clocks and samples dut_out on the last one. The result is
// reported as an 8-bit truth-table code, with row 000 in the MSB.
// Optional feature macro: TRUTH_TABLE_PROBE_CHECK_EN adds an `expected` input
// and a `mismatch` flag that compares each finished sweep against `expected`.
module truth_table_probe #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
`ifdef TRUTH_TABLE_PROBE_CHECK_EN
  input  logic [7:0] expected,
  output logic       mismatch,
`endif
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_code
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned CODE_W = 8;

  // Value of the settle counter on the last cycle a row is held.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(7);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [ROW_W-1:0]    row, row_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CODE_W-1:0]   capture, capture_nxt;
  logic [CODE_W-1:0]   code_nxt;
  logic [ROW_W-1:0]    drive_nxt;
  logic                busy_nxt;
  logic                done_nxt;
  logic [ROW_W-1:0]    drive_q;

  // Next-state, row/settle sequencing, capture and registered-output values.
  always_comb begin
    state_nxt   = state;
    row_nxt     = row;
    cnt_nxt     = cnt;
    capture_nxt = capture;
    code_nxt    = table_code;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = APPLY;
          row_nxt     = '0;
          cnt_nxt     = '0;
          capture_nxt = '0;
        end
      end

      APPLY: begin
        if (cnt == SETTLE_LAST) begin
          // Row k lands in bit 7-k so row 000 ends up in the MSB.
          capture_nxt[ROW_W'(7) - row] = dut_out;
          cnt_nxt = '0;
          if (row == ROW_LAST) begin
            state_nxt = DONE;
            row_nxt   = '0;
            // Publish together with the done pulse.
            code_nxt  = capture_nxt;
          end else begin
            row_nxt = row + ROW_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with it.
    drive_nxt = (state_nxt == APPLY) ? row_nxt : '0;
    busy_nxt  = (state_nxt == APPLY);
    done_nxt  = (state_nxt == DONE);
  end

  // State, sequencing and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      cnt        <= '0;
      capture    <= '0;
      table_code <= '0;
      drive_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      cnt        <= cnt_nxt;
      capture    <= capture_nxt;
      table_code <= code_nxt;
      drive_q    <= drive_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  assign in1 = drive_q[2];
  assign in2 = drive_q[1];
  assign in3 = drive_q[0];

`ifdef TRUTH_TABLE_PROBE_CHECK_EN
  // Compare the finished capture against `expected`, sampled in DONE only.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch <= 1'b0;
    end else if (state == DONE) begin
      mismatch <= (capture != expected);
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_probe.sv
// Scoreboard bench for truth_table_probe: a behavioural gate with programmable
// truth table and input delay drives dut_out; stimulus predicts codes and done
// times, and a negedge monitor checks them as the DUT reports.
module tb_truth_table_probe;

  localparam int unsigned S     = 4;
  localparam int unsigned SWEEP = 8 * S;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dut_out;
  logic       in1, in2, in3;
  logic       busy, done;
  logic [7:0] table_code;
`ifdef TRUTH_TABLE_PROBE_CHECK_EN
  logic [7:0] expected;
  logic       mismatch;
  assign expected = 8'hE8;
`endif

  truth_table_probe #(.SETTLE_CYCLES(S)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dut_out    (dut_out),
`ifdef TRUTH_TABLE_PROBE_CHECK_EN
    .expected   (expected),
    .mismatch   (mismatch),
`endif
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .busy       (busy),
    .done       (done),
    .table_code (table_code)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate under test: truth table byte (row 000 in MSB) seen through a delay line.
  logic [7:0] gate_tt;
  logic [2:0] gate_dly;
  logic [2:0] hist [0:7];

  always @(posedge clk) begin
    hist[0] <= {in1, in2, in3};
    for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
  end

  always_comb begin
    logic [2:0] idx;
    idx     = (gate_dly == 3'd0) ? {in1, in2, in3} : hist[gate_dly - 3'd1];
    dut_out = gate_tt[3'd7 - idx];
  end

  typedef struct {
    logic [7:0]  code;
    int unsigned at;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          fails  = 0;
  logic        mon_en = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Code a probe should report: the sample for row k is the row that was being
  // driven d cycles before the last settle cycle of row k (idle drives row 0).
  function automatic logic [7:0] predict(input logic [7:0] tt, input int d);
    logic [7:0] c;
    for (int k = 0; k < 8; k++) begin
      int off;
      int r;
      off = k * int'(S) + int'(S) - 1 - d;
      r   = (off < 0) ? 0 : off / int'(S);
      c[7-k] = tt[7-r];
    end
    return c;
  endfunction

  // Monitor: checks held code, row drive, idle inputs and every done pulse.
  logic [7:0]  model_code = 8'h00;
  int unsigned row_cyc    = 0;
  logic        rst_seen   = 1'b0;
`ifdef TRUTH_TABLE_PROBE_CHECK_EN
  logic        mm_chk = 1'b0;
  logic        mm_exp = 1'b0;
`endif

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) model_code = 8'h00;
`ifdef TRUTH_TABLE_PROBE_CHECK_EN
      if (rst_seen) mm_chk = 1'b0;
      if (mm_chk) begin
        check("mismatch", 32'(mismatch), 32'(mm_exp));
        mm_chk = 1'b0;
      end
`endif
      if (done) begin
        if (sbq.size() == 0) begin
          check("spurious_done", 32'(done), 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("done_cycle", cyc, e.at);
          check("table_code", 32'(table_code), 32'(e.code));
          check("busy_len", row_cyc, SWEEP);
          check("done_busy", 32'(busy), 0);
          model_code = e.code;
`ifdef TRUTH_TABLE_PROBE_CHECK_EN
          mm_exp = (e.code != 8'hE8);
          mm_chk = 1'b1;
`endif
        end
      end else begin
        check("code_hold", 32'(table_code), 32'(model_code));
      end
      if (busy) begin
        check("row_drive", 32'({in1, in2, in3}), row_cyc / S);
        row_cyc++;
      end else begin
        check("idle_inputs", 32'({in1, in2, in3}), 0);
        row_cyc = 0;
      end
    end
    rst_seen = rst;
  end

  // Wait (bounded) until every predicted done has been seen.
  task automatic drain();
    int unsigned n = 0;
    while (sbq.size() != 0 && n < 4 * SWEEP + 50) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic sweep(input logic [7:0] tt, input logic [2:0] d);
    exp_t e;
    repeat (10) @(posedge clk);
    #1;
    gate_tt  = tt;
    gate_dly = d;
    @(posedge clk);
    #1;
    start = 1'b1;
    e.code = predict(tt, int'(d));
    e.at   = cyc + SWEEP + 1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
  endtask

  // Hold start for len cycles; it is only honoured when the probe is idle.
  task automatic hold_start(input logic [7:0] tt, input int unsigned len);
    int unsigned c0;
    exp_t        e;
    repeat (10) @(posedge clk);
    #1;
    gate_tt  = tt;
    gate_dly = 3'd0;
    @(posedge clk);
    #1;
    start = 1'b1;
    c0    = cyc;
    for (int unsigned i = 0; i * (SWEEP + 2) <= len - 1; i++) begin
      e.code = tt;
      e.at   = c0 + i * (SWEEP + 2) + SWEEP + 1;
      sbq.push_back(e);
    end
    repeat (len) @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (SWEEP + 10) @(posedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    gate_tt  = 8'h00;
    gate_dly = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_code", 32'(table_code), 0);
    check("rst_inputs", 32'({in1, in2, in3}), 0);
    mon_en = 1'b1;

    // At most one input high, AND, and out = in1.
    sweep(8'hE8, 3'd0);
    sweep(8'h01, 3'd0);
    sweep(8'h0F, 3'd0);
    // Gate with two cycles of input delay still settles within a row.
    sweep(8'hE8, 3'd2);
    // Delays at or beyond the settle window pick up the previous row.
    sweep(8'hE8, 3'd4);
    sweep(8'h96, 3'd5);

    for (int i = 0; i < 10; i++) begin
      sweep(8'($urandom), 3'($urandom_range(0, 3)));
    end

    // Continuous start: back-to-back sweeps only, nothing queued.
    hold_start(8'h6C, 100);

    // Abort mid-sweep: no done, code cleared, inputs released.
    repeat (5) @(posedge clk);
    #1;
    gate_tt = 8'hE8;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_code", 32'(table_code), 0);
    check("abort_inputs", 32'({in1, in2, in3}), 0);
    repeat (SWEEP + 10) @(posedge clk);

    // Reset wins over a simultaneous start.
    #1;
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    check("rst_over_start", 32'(busy), 0);
    repeat (SWEEP + 10) @(posedge clk);

    sweep(8'hE8, 3'd0);

    check("queue_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
